// File: rtl/fft_symbol_sched.sv
// -----------------------------------------------------------------------------
// fft_symbol_sched
//
// Frame scheduler in front of a streaming FFT core. On an accepted start it
// sends one configuration word to the core. It then passes num_symbols *
// FFT_LEN samples from the sample source to the core's data port with zero
// latency, marking the last sample of every symbol with tlast. It ends the
// frame with a one-cycle done pulse. Error events reported by the core set a
// sticky err flag.
//
// Build option:
//   FFT_SCHED_ERR_CNT_EN  when defined, err_cnt counts cycles with any error
//                         event high (saturating at 255, cleared only by RST).
//                         When undefined, err_cnt is tied to 0.
//
// Ports:
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   start, num_symbols       frame request; num_symbols latched on acceptance
//   s_axis_*                 sample source (tdata/tvalid in, tready out)
//   m_axis_data_*            FFT data input port (tdata/tvalid/tlast out, tready in)
//   m_axis_config_*          FFT config port (tdata/tvalid out, tready in)
//   event_tlast_unexpected,
//   event_tlast_missing      FFT core error events
//   busy, done               frame in progress / end-of-frame pulse
//   err, err_cnt             sticky error flag / error event count
// -----------------------------------------------------------------------------
module fft_symbol_sched #(
  parameter int         FFT_LEN   = 64,
  parameter logic       FWD_INV   = 1'b0,
  parameter logic [7:0] SCALE_SCH = 8'b01101010
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [7:0]  num_symbols,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_data_tdata,
  output logic        m_axis_data_tvalid,
  input  logic        m_axis_data_tready,
  output logic        m_axis_data_tlast,
  output logic [15:0] m_axis_config_tdata,
  output logic        m_axis_config_tvalid,
  input  logic        m_axis_config_tready,
  input  logic        event_tlast_unexpected,
  input  logic        event_tlast_missing,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam int              CW        = $clog2(FFT_LEN);
  localparam logic [CW-1:0]   LAST_SAMP = CW'(FFT_LEN - 1);
  localparam logic [15:0]     CFG_WORD  = {7'b0, SCALE_SCH, FWD_INV};

  typedef enum logic [1:0] {IDLE, CONFIG, STREAM, DONE} state_t;

  state_t        state_q;
  logic [7:0]    nsym_q;      // symbols in the current frame
  logic [7:0]    sym_q;       // symbols completed so far
  logic [CW-1:0] samp_q;      // sample index within the current symbol
  logic          busy_q;
  logic          done_q;
  logic          cfg_vld_q;
  logic          strm_q;      // registered copy of (state_q == STREAM)
  logic          err_q;

  logic accept;
  logic xfer;
  logic sym_end;
  logic any_event;

  assign accept    = (state_q == IDLE) && start && (num_symbols != 8'd0);
  assign xfer      = strm_q && s_axis_tvalid && m_axis_data_tready;
  assign sym_end   = samp_q == LAST_SAMP;
  assign any_event = event_tlast_unexpected || event_tlast_missing;

  // Data path is a pure pass-through while streaming; everything is gated to 0
  // outside STREAM so the core never sees stray valids or data.
  assign s_axis_tready        = strm_q && m_axis_data_tready;
  assign m_axis_data_tvalid   = strm_q && s_axis_tvalid;
  assign m_axis_data_tdata    = strm_q ? s_axis_tdata : '0;
  // tlast follows the counter, not the handshake, so it is already high while
  // the source stalls on the last sample of a symbol.
  assign m_axis_data_tlast    = strm_q && sym_end;

  assign m_axis_config_tvalid = cfg_vld_q;
  assign m_axis_config_tdata  = cfg_vld_q ? CFG_WORD : '0;

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

  // Frame FSM with its counters and registered status outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      nsym_q    <= '0;
      sym_q     <= '0;
      samp_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_vld_q <= 1'b0;
      strm_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= CONFIG;
            nsym_q    <= num_symbols;
            sym_q     <= '0;
            samp_q    <= '0;
            busy_q    <= 1'b1;
            cfg_vld_q <= 1'b1;
          end
        end
        CONFIG: begin
          if (m_axis_config_tready) begin
            state_q   <= STREAM;
            cfg_vld_q <= 1'b0;
            strm_q    <= 1'b1;
          end
        end
        STREAM: begin
          if (xfer) begin
            samp_q <= sym_end ? '0 : samp_q + 1'b1;
            if (sym_end) begin
              sym_q <= sym_q + 8'd1;
              if (sym_q == nsym_q - 8'd1) begin
                state_q <= DONE;
                strm_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky error: an event in the same cycle as an accepted start wins.
  always_ff @(posedge CLK) begin
    if (RST)            err_q <= 1'b0;
    else if (any_event) err_q <= 1'b1;
    else if (accept)    err_q <= 1'b0;
  end

`ifdef FFT_SCHED_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST)                                  err_cnt_q <= '0;
    else if (any_event && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_fft_symbol_sched.sv
// -----------------------------------------------------------------------------
// tb_fft_symbol_sched
//
// Self-checking bench for fft_symbol_sched. A frame-level reference model
// (phase plus a running transfer count per frame) predicts every output each
// cycle. A monitor records per-frame observations (transfer count, tlast
// positions, config word, stalls) that directed tests pin with literal values.
// -----------------------------------------------------------------------------
module tb_fft_symbol_sched;

  localparam int         FFT_LEN   = 64;
  localparam logic       FWD_INV   = 1'b0;
  localparam logic [7:0] SCALE_SCH = 8'b01101010;
  localparam int         CFG_EXP   = int'(SCALE_SCH) * 2 + int'(FWD_INV);
`ifdef FFT_SCHED_ERR_CNT_EN
  localparam int         ERRCNT_ON = 1;
`else
  localparam int         ERRCNT_ON = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_symbols = 8'd0;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_data_tdata;
  logic        m_axis_data_tvalid;
  logic        m_axis_data_tready;
  logic        m_axis_data_tlast;
  logic [15:0] m_axis_config_tdata;
  logic        m_axis_config_tvalid;
  logic        m_axis_config_tready;
  logic        event_tlast_unexpected = 1'b0;
  logic        event_tlast_missing = 1'b0;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  err_cnt;

  always #5 CLK = ~CLK;

  fft_symbol_sched #(
    .FFT_LEN  (FFT_LEN),
    .FWD_INV  (FWD_INV),
    .SCALE_SCH(SCALE_SCH)
  ) dut (
    .CLK                   (CLK),
    .RST                   (RST),
    .start                 (start),
    .num_symbols           (num_symbols),
    .s_axis_tdata          (s_axis_tdata),
    .s_axis_tvalid         (s_axis_tvalid),
    .s_axis_tready         (s_axis_tready),
    .m_axis_data_tdata     (m_axis_data_tdata),
    .m_axis_data_tvalid    (m_axis_data_tvalid),
    .m_axis_data_tready    (m_axis_data_tready),
    .m_axis_data_tlast     (m_axis_data_tlast),
    .m_axis_config_tdata   (m_axis_config_tdata),
    .m_axis_config_tvalid  (m_axis_config_tvalid),
    .m_axis_config_tready  (m_axis_config_tready),
    .event_tlast_unexpected(event_tlast_unexpected),
    .event_tlast_missing   (event_tlast_missing),
    .busy                  (busy),
    .done                  (done),
    .err                   (err),
    .err_cnt               (err_cnt)
  );

  // ---------------------------------------------------------------- checking
  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------- reference model
  // Phase: 0 idle, 1 config, 2 stream, 3 done. m_xfers counts data transfers
  // since the frame started; symbol boundaries fall out of m_xfers % FFT_LEN.
  int   m_phase = 0;
  int   m_nsym = 0;
  int   m_xfers = 0;
  logic m_err = 1'b0;
  int   m_errcnt = 0;

  always @(posedge CLK) begin
    if (RST) begin
      m_phase  <= 0;
      m_nsym   <= 0;
      m_xfers  <= 0;
      m_err    <= 1'b0;
      m_errcnt <= 0;
    end else begin
      if (event_tlast_unexpected || event_tlast_missing) m_err <= 1'b1;
      else if (m_phase == 0 && start && num_symbols != 8'd0) m_err <= 1'b0;
      if (ERRCNT_ON != 0 && (event_tlast_unexpected || event_tlast_missing) && m_errcnt < 255)
        m_errcnt <= m_errcnt + 1;
      case (m_phase)
        0: if (start && num_symbols != 8'd0) begin
             m_phase <= 1;
             m_nsym  <= int'(num_symbols);
             m_xfers <= 0;
           end
        1: if (m_axis_config_tready) m_phase <= 2;
        2: if (s_axis_tvalid && m_axis_data_tready) begin
             m_xfers <= m_xfers + 1;
             if (m_xfers + 1 == m_nsym * FFT_LEN) m_phase <= 3;
           end
        default: m_phase <= 0;
      endcase
    end
  end

  // ------------------------------------------------- compare + observation
  int         fr_xfers = 0;     // transfers seen in the current frame
  int         tlast_q[$];       // 1-based transfer numbers carrying tlast
  int         cfg_cycles = 0;
  int         cfg_stall = 0;
  int         sready_pre = 0;   // s_tready cycles before config handshake
  int         data_bad = 0;
  bit         cfg_hs = 1'b0;
  logic [15:0] cfg_last = '0;
  int         done_cnt = 0;

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("busy",       32'(busy),                 32'(m_phase != 0));
      check("done",       32'(done),                 32'(m_phase == 3));
      check("cfg_tvalid", 32'(m_axis_config_tvalid), 32'(m_phase == 1));
      check("cfg_tdata",  32'(m_axis_config_tdata),  (m_phase == 1) ? 32'(CFG_EXP) : 32'd0);
      check("s_tready",   32'(s_axis_tready),        32'(m_phase == 2 && m_axis_data_tready));
      check("m_tvalid",   32'(m_axis_data_tvalid),   32'(m_phase == 2 && s_axis_tvalid));
      check("m_tdata",    m_axis_data_tdata,         (m_phase == 2) ? s_axis_tdata : 32'd0);
      check("m_tlast",    32'(m_axis_data_tlast),
            32'(m_phase == 2 && (m_xfers % FFT_LEN) == FFT_LEN - 1));
      check("err",        32'(err),                  32'(m_err));
      check("err_cnt",    32'(err_cnt),              32'(m_errcnt));

      if (!RST && m_phase == 0 && start && num_symbols != 8'd0) begin
        fr_xfers   = 0;
        tlast_q.delete();
        cfg_cycles = 0;
        cfg_stall  = 0;
        sready_pre = 0;
        data_bad   = 0;
        cfg_hs     = 1'b0;
      end
      if (m_axis_config_tvalid) begin
        cfg_cycles++;
        cfg_last = m_axis_config_tdata;
        if (m_axis_config_tready) cfg_hs = 1'b1;
        else                      cfg_stall++;
      end
      if (s_axis_tready && !cfg_hs) sready_pre++;
      if (m_axis_data_tvalid && m_axis_data_tready) begin
        fr_xfers++;
        if (m_axis_data_tlast) tlast_q.push_back(fr_xfers);
        if (m_axis_data_tdata != s_axis_tdata) data_bad++;
      end
      if (done) done_cnt++;
    end
  end

  function automatic int tlast_at(input int i);
    return (i < tlast_q.size()) ? tlast_q[i] : -1;
  endfunction

  // --------------------------------------------------------- stream driver
  // mode 1: source and sink always ready; mode 2: random stalls on both sides
  // and on the config port. cfg_hold forces config tready low.
  int mode = 1;
  bit cfg_hold = 1'b0;

  initial begin
    s_axis_tdata         = '0;
    s_axis_tvalid        = 1'b0;
    m_axis_data_tready   = 1'b0;
    m_axis_config_tready = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      s_axis_tdata = $urandom;
      if (mode == 2) begin
        s_axis_tvalid      = ($urandom_range(0, 3) != 0);
        m_axis_data_tready = ($urandom_range(0, 1) != 0);
      end else begin
        s_axis_tvalid      = 1'b1;
        m_axis_data_tready = 1'b1;
      end
      if (cfg_hold)       m_axis_config_tready = 1'b0;
      else if (mode == 2) m_axis_config_tready = ($urandom_range(0, 1) != 0);
      else                m_axis_config_tready = 1'b1;
    end
  end

  // ------------------------------------------------------------ main tasks
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_start(input int n);
    start       = 1'b1;
    num_symbols = 8'(n);
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0   = done_cnt;
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, " done seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " busy"},       32'(busy),                 32'd0);
    check({name, " done"},       32'(done),                 32'd0);
    check({name, " cfg_tvalid"}, 32'(m_axis_config_tvalid), 32'd0);
    check({name, " cfg_tdata"},  32'(m_axis_config_tdata),  32'd0);
    check({name, " s_tready"},   32'(s_axis_tready),        32'd0);
    check({name, " m_tvalid"},   32'(m_axis_data_tvalid),   32'd0);
    check({name, " m_tlast"},    32'(m_axis_data_tlast),    32'd0);
    check({name, " m_tdata"},    m_axis_data_tdata,         32'd0);
    check({name, " err"},        32'(err),                  32'd0);
    check({name, " err_cnt"},    32'(err_cnt),              32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0;
    int n;

    // Reset
    RST = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    check_idle_outputs("reset");
    RST = 1'b0;
    tick();

    // Two symbols, everything ready
    mode = 1;
    d0   = done_cnt;
    do_start(2);
    wait_done(400, "basic");
    check("basic xfers",      32'(fr_xfers),     32'd128);
    check("basic tlast cnt",  32'(tlast_q.size()), 32'd2);
    check("basic tlast0",     32'(tlast_at(0)),  32'd64);
    check("basic tlast1",     32'(tlast_at(1)),  32'd128);
    check("basic cfg cycles", 32'(cfg_cycles),   32'd1);
    check("basic cfg word",   32'(cfg_last),     32'h00D4);
    tick();
    check("basic busy after", 32'(busy),         32'd0);
    check("basic done once",  32'(done_cnt - d0), 32'd1);

    // Config port stalled for 5 cycles. The driver applies cfg_hold one
    // cycle late, so releasing it after 4 ticks yields exactly 5 stalls.
    cfg_hold = 1'b1;
    tick();
    do_start(1);
    repeat (4) tick();
    cfg_hold = 1'b0;
    wait_done(400, "cfg stall");
    check("cfg stall cycles", 32'(cfg_stall),  32'd5);
    check("cfg stall total",  32'(cfg_cycles), 32'd6);
    check("cfg stall word",   32'(cfg_last),   32'h00D4);
    check("cfg early tready", 32'(sready_pre), 32'd0);
    check("cfg stall xfers",  32'(fr_xfers),   32'd64);

    // Ignored starts: num_symbols=0 in IDLE, and start during STREAM
    d0 = done_cnt;
    do_start(0);
    check("zero start busy", 32'(busy), 32'd0);
    do_start(1);
    repeat (10) tick();
    do_start(5);
    wait_done(400, "ignored start");
    check("ignored xfers",     32'(fr_xfers),       32'd64);
    check("ignored tlast cnt", 32'(tlast_q.size()), 32'd1);
    tick();
    check("ignored done once", 32'(done_cnt - d0),  32'd1);
    check("ignored busy",      32'(busy),           32'd0);

    // Random stalls, three symbols
    mode = 2;
    do_start(3);
    wait_done(3000, "random");
    check("random xfers",     32'(fr_xfers),       32'd192);
    check("random tlast cnt", 32'(tlast_q.size()), 32'd3);
    check("random tlast0",    32'(tlast_at(0)),    32'd64);
    check("random tlast1",    32'(tlast_at(1)),    32'd128);
    check("random tlast2",    32'(tlast_at(2)),    32'd192);
    check("random data",      32'(data_bad),       32'd0);
    for (int f = 0; f < 3; f++) begin
      tick();
      n = $urandom_range(1, 4);
      do_start(n);
      wait_done(4000, "random frame");
      check("random frame xfers", 32'(fr_xfers),       32'(n * FFT_LEN));
      check("random frame tlast", 32'(tlast_q.size()), 32'(n));
    end
    mode = 1;
    tick();

    // Reset mid-frame
    d0 = done_cnt;
    do_start(2);
    for (int i = 0; i < 200 && fr_xfers < 30; i++) tick();
    check("midrst reached 30", 32'(fr_xfers >= 30), 32'd1);
    RST = 1'b1;
    tick();
    check_idle_outputs("midrst");
    RST = 1'b0;
    repeat (3) tick();
    check("midrst no done", 32'(done_cnt - d0), 32'd0);
    do_start(1);
    wait_done(400, "after reset");
    check("after reset tlast cnt", 32'(tlast_q.size()), 32'd1);
    check("after reset tlast0",    32'(tlast_at(0)),    32'd64);
    tick();

    // Error events
    for (int i = 0; i < 3; i++) begin
      event_tlast_missing = 1'b1;
      tick();
      event_tlast_missing = 1'b0;
      tick();
    end
    check("events err",     32'(err),     32'd1);
    check("events err_cnt", 32'(err_cnt), 32'(3 * ERRCNT_ON));
    do_start(1);
    check("start clears err",      32'(err),     32'd0);
    check("start keeps err_cnt",   32'(err_cnt), 32'(3 * ERRCNT_ON));
    wait_done(400, "err frame");
    tick();
    event_tlast_unexpected = 1'b1;
    do_start(1);
    event_tlast_unexpected = 1'b0;
    check("event with start err",     32'(err),     32'd1);
    check("event with start err_cnt", 32'(err_cnt), 32'(4 * ERRCNT_ON));
    wait_done(400, "err start frame");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
